// File: rtl/laser_frame_scheduler_if.sv
// rtl/laser_frame_scheduler_if.sv - sync input, controls and laser/status outputs of the frame scheduler
interface laser_frame_scheduler_if #(
  parameter int CNT_W = 24
);
  logic             V_SYNC;
  logic             ENABLE;
  logic             STEP;
  logic [1:0]       MODE;
  logic             SYNC_0;
  logic             SYNC_1;
  logic [3:0]       OFFSET_IDX;
  logic [CNT_W-1:0] FRAME_PERIOD;
  logic             LOCKED;
  logic             FRAME_TICK;

  modport master (
    output V_SYNC, ENABLE, STEP, MODE,
    input  SYNC_0, SYNC_1, OFFSET_IDX, FRAME_PERIOD, LOCKED, FRAME_TICK
  );

  modport slave (
    input  V_SYNC, ENABLE, STEP, MODE,
    output SYNC_0, SYNC_1, OFFSET_IDX, FRAME_PERIOD, LOCKED, FRAME_TICK
  );
endinterface

// File: rtl/laser_frame_scheduler.sv
// rtl/laser_frame_scheduler.sv - V_SYNC-locked A/B laser alternation at a 1/16-frame offset with dead time
module laser_frame_scheduler #(
  parameter int CNT_W         = 24,
  parameter int DEAD_TICKS    = 3000,
  parameter int TIMEOUT_TICKS = 2000000
) (
  input logic                    CLK,
  input logic                    RST,
  laser_frame_scheduler_if.slave bus
);

  localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [DW-1:0]    DEAD_LAST = DW'(DEAD_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_TICKS);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_SYNC, S_ARM, S_DEAD, S_ON} state_t;

  state_t           state_q, state_d;
  logic             vs_meta_q, vs_meta_d, vs_sync_q, vs_sync_d;
  logic             vs_prev_q, vs_prev_d, vs_rise_q, vs_rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [CNT_W-1:0] delay_q, delay_d, phase_q, phase_d;
  logic             seen_q, seen_d, locked_q, locked_d;
  logic [3:0]       shadow_q, shadow_d, idx_q, idx_d;
  logic [DW-1:0]    dead_q, dead_d;
  logic             parity_q, parity_d, been_on_q, been_on_d;
  logic             sync0_q, sync0_d, sync1_q, sync1_d, tick_q, tick_d;

  logic             vs_rise, timeout, hit, drive, sel_a, sel_b;
  logic [CNT_W-1:0] cnt_inc, phase_inc, period_new, delay_new, phase_eff, delay_eff;
  logic [CNT_W+3:0] prod;

  always_comb begin
    vs_meta_d  = bus.V_SYNC;
    vs_sync_d  = vs_meta_q;
    vs_prev_d  = vs_sync_q;
    vs_rise_d  = vs_sync_q & ~vs_prev_q;
    vs_rise    = vs_rise_q;

    cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    phase_inc  = (&phase_q) ? phase_q : phase_q + 1'b1;
    timeout    = !vs_rise && (cnt_q == TIMEOUT_C);
    shadow_d   = shadow_q + {3'b000, bus.STEP};
    // The first edge after reset/timeout has no valid period, so the held one feeds the delay.
    period_new = seen_q ? cnt_inc : period_q;
    prod       = {4'b0000, period_new} * {{CNT_W{1'b0}}, shadow_d};
    delay_new  = CNT_W'(prod >> 4);

    cnt_d    = cnt_inc;
    phase_d  = phase_inc;
    period_d = period_q;
    seen_d   = seen_q;
    locked_d = locked_q;
    idx_d    = idx_q;
    delay_d  = delay_q;
    tick_d   = vs_rise & locked_q;

    if (vs_rise) begin
      cnt_d   = '0;
      seen_d  = 1'b1;
      idx_d   = shadow_d;
      delay_d = delay_new;
      phase_d = CNT_W'(1);
      if (seen_q) begin
        period_d = cnt_inc;
        locked_d = 1'b1;
      end
    end else if (timeout) begin
      seen_d   = 1'b0;
      locked_d = 1'b0;
    end

    // The vs_rise cycle itself is phase 0, so a zero delay switches on that cycle.
    phase_eff = vs_rise ? '0 : phase_q;
    delay_eff = vs_rise ? delay_new : delay_q;
    hit       = (phase_eff == delay_eff);

    state_d   = state_q;
    dead_d    = dead_q;
    parity_d  = parity_q;
    been_on_d = been_on_q;

    if (!bus.ENABLE) begin
      state_d = S_IDLE;
    end else if (timeout) begin
      state_d = S_WAIT_SYNC;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!locked_q)    state_d = S_WAIT_SYNC;
          else if (vs_rise) state_d = S_ARM;
        end
        S_WAIT_SYNC: begin
          if (vs_rise && seen_q) state_d = S_ARM;
        end
        S_ARM: begin
          if (hit) begin
            parity_d = ~parity_q;
            dead_d   = '0;
            state_d  = S_DEAD;
          end
        end
        S_DEAD: begin
          if (dead_q == DEAD_LAST) begin
            been_on_d = 1'b1;
            state_d   = S_ON;
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
        S_ON: begin
          if (vs_rise) begin
            if (hit) begin
              parity_d = ~parity_q;
              dead_d   = '0;
              state_d  = S_DEAD;
            end else begin
              state_d = S_ARM;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_IDLE || state_d == S_WAIT_SYNC) begin
      parity_d  = 1'b0;
      been_on_d = 1'b0;
    end

    sel_a = 1'b0;
    sel_b = 1'b0;
    case (bus.MODE)
      2'b00: begin sel_a = parity_d; sel_b = ~parity_d; end
      2'b01: sel_a = 1'b1;
      2'b10: sel_b = 1'b1;
      default: ;
    endcase
    // Outputs follow the next state so every change lands on the same edge as the state.
    drive   = (state_d == S_ON) || (state_d == S_ARM && been_on_d);
    sync0_d = drive & sel_a;
    sync1_d = drive & sel_b;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      vs_meta_q <= 1'b0;
      vs_sync_q <= 1'b0;
      vs_prev_q <= 1'b0;
      vs_rise_q <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      delay_q   <= '0;
      phase_q   <= '0;
      seen_q    <= 1'b0;
      locked_q  <= 1'b0;
      shadow_q  <= '0;
      idx_q     <= '0;
      dead_q    <= '0;
      parity_q  <= 1'b0;
      been_on_q <= 1'b0;
      sync0_q   <= 1'b0;
      sync1_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_meta_q <= vs_meta_d;
      vs_sync_q <= vs_sync_d;
      vs_prev_q <= vs_prev_d;
      vs_rise_q <= vs_rise_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      delay_q   <= delay_d;
      phase_q   <= phase_d;
      seen_q    <= seen_d;
      locked_q  <= locked_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      dead_q    <= dead_d;
      parity_q  <= parity_d;
      been_on_q <= been_on_d;
      sync0_q   <= sync0_d;
      sync1_q   <= sync1_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.SYNC_0       = sync0_q;
  assign bus.SYNC_1       = sync1_q;
  assign bus.OFFSET_IDX   = idx_q;
  assign bus.FRAME_PERIOD = period_q;
  assign bus.LOCKED       = locked_q;
  assign bus.FRAME_TICK   = tick_q;

endmodule

// File: tb/tb_laser_frame_scheduler.sv
// tb/tb_laser_frame_scheduler.sv - directed bench for laser_frame_scheduler (DEAD_TICKS=4, TIMEOUT_TICKS=5000)
module tb_laser_frame_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pend_rise = -1;
  int   overlap = 0;
  int   ph = 1599;
  int   vs_period = 1600;
  bit   vs_on = 1'b0;

  laser_frame_scheduler_if #(.CNT_W(24)) bus ();

  laser_frame_scheduler #(
    .CNT_W(24),
    .DEAD_TICKS(4),
    .TIMEOUT_TICKS(5000)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.SYNC_0 && bus.SYNC_1) overlap = overlap + 1;
  end

  // V_SYNC source; pend_rise is the cycle in which the DUT's internal vs_rise is high.
  initial begin
    bus.V_SYNC = 1'b0;
    forever begin
      @(negedge clk);
      if (vs_on) begin
        ph = (ph >= vs_period - 1) ? 0 : ph + 1;
        if (ph == 0) pend_rise = cyc + 3;
        bus.V_SYNC = (ph < 50);
      end else begin
        ph = vs_period - 1;
        bus.V_SYNC = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
    $fatal(1);
  end

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_vsr(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cyc != pend_rise && n < 4000);
    if (cyc != pend_rise) begin
      checks++;
      errors++;
      $display("FAIL %s: no vs_rise after %0d cycles, required within 4000", name, n);
    end
  endtask

  task automatic pulse_step(input int n);
    repeat (n) begin
      bus.STEP = 1'b1;
      @(negedge clk);
      bus.STEP = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.ENABLE = 1'b0;
    bus.MODE = 2'b00;
    bus.STEP = 1'b0;
    skip(3);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1, bus.LOCKED, bus.FRAME_TICK} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000", {bus.SYNC_0, bus.SYNC_1, bus.LOCKED, bus.FRAME_TICK});
    end
    checks++;
    if (bus.OFFSET_IDX !== 4'd0) begin
      errors++;
      $display("FAIL reset_idx: got %0d required 0", bus.OFFSET_IDX);
    end
    checks++;
    if (bus.FRAME_PERIOD !== 24'd0) begin
      errors++;
      $display("FAIL reset_period: got %0d required 0", bus.FRAME_PERIOD);
    end
  endtask

  task automatic test_alternate;
    rst = 1'b0;
    bus.ENABLE = 1'b1;
    vs_on = 1'b1;
    wait_vsr("lock_edge1");
    wait_vsr("lock_edge2");
    skip(1);
    checks++;
    if (bus.LOCKED !== 1'b1) begin
      errors++;
      $display("FAIL lock_after_2nd: got %b required 1", bus.LOCKED);
    end
    checks++;
    if (bus.FRAME_PERIOD !== 24'd1600) begin
      errors++;
      $display("FAIL period_1600: got %0d required 1600", bus.FRAME_PERIOD);
    end
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b00) begin
      errors++;
      $display("FAIL first_arm_off: got %b required 00", {bus.SYNC_0, bus.SYNC_1});
    end
    wait_vsr("alt_edge3");
    skip(1);
    checks++;
    if ({bus.FRAME_TICK, bus.SYNC_0, bus.SYNC_1} !== 3'b100) begin
      errors++;
      $display("FAIL tick_dead_start: got %b required 100", {bus.FRAME_TICK, bus.SYNC_0, bus.SYNC_1});
    end
    skip(3);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b00) begin
      errors++;
      $display("FAIL dead_end: got %b required 00", {bus.SYNC_0, bus.SYNC_1});
    end
    skip(1);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b10) begin
      errors++;
      $display("FAIL first_on_a: got %b required 10", {bus.SYNC_0, bus.SYNC_1});
    end
    wait_vsr("alt_edge4");
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b10) begin
      errors++;
      $display("FAIL a_until_edge: got %b required 10", {bus.SYNC_0, bus.SYNC_1});
    end
    skip(5);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b01) begin
      errors++;
      $display("FAIL second_on_b: got %b required 01", {bus.SYNC_0, bus.SYNC_1});
    end
    wait_vsr("alt_edge5");
    skip(5);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b10) begin
      errors++;
      $display("FAIL third_on_a: got %b required 10", {bus.SYNC_0, bus.SYNC_1});
    end
  endtask

  task automatic test_step_offset;
    skip(300);
    pulse_step(4);
    checks++;
    if (bus.OFFSET_IDX !== 4'd0) begin
      errors++;
      $display("FAIL idx_mid_frame: got %0d required 0", bus.OFFSET_IDX);
    end
    wait_vsr("step_edge");
    skip(1);
    checks++;
    if (bus.OFFSET_IDX !== 4'd4) begin
      errors++;
      $display("FAIL idx_loaded_4: got %0d required 4", bus.OFFSET_IDX);
    end
    skip(399);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b10) begin
      errors++;
      $display("FAIL arm_hold_at_400: got %b required 10", {bus.SYNC_0, bus.SYNC_1});
    end
    skip(1);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b00) begin
      errors++;
      $display("FAIL dead_at_401: got %b required 00", {bus.SYNC_0, bus.SYNC_1});
    end
    skip(3);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b00) begin
      errors++;
      $display("FAIL dead_at_404: got %b required 00", {bus.SYNC_0, bus.SYNC_1});
    end
    skip(1);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b01) begin
      errors++;
      $display("FAIL on_b_at_405: got %b required 01", {bus.SYNC_0, bus.SYNC_1});
    end
  endtask

  task automatic test_wrap;
    skip(95);
    pulse_step(16);
    checks++;
    if (bus.OFFSET_IDX !== 4'd4) begin
      errors++;
      $display("FAIL idx_hold_after_16: got %0d required 4", bus.OFFSET_IDX);
    end
    wait_vsr("wrap_edge");
    bus.STEP = 1'b1;
    @(negedge clk);
    bus.STEP = 1'b0;
    checks++;
    if (bus.OFFSET_IDX !== 4'd5) begin
      errors++;
      $display("FAIL idx_wrap_same_cycle: got %0d required 5", bus.OFFSET_IDX);
    end
    skip(499);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b01) begin
      errors++;
      $display("FAIL arm_hold_at_500: got %b required 01", {bus.SYNC_0, bus.SYNC_1});
    end
    skip(5);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b10) begin
      errors++;
      $display("FAIL on_a_at_505: got %b required 10", {bus.SYNC_0, bus.SYNC_1});
    end
  endtask

  task automatic test_timeout;
    skip(95);
    vs_on = 1'b0;
    skip(4390);
    checks++;
    if ({bus.LOCKED, bus.SYNC_0, bus.SYNC_1} !== 3'b110) begin
      errors++;
      $display("FAIL before_timeout: got %b required 110", {bus.LOCKED, bus.SYNC_0, bus.SYNC_1});
    end
    skip(20);
    checks++;
    if ({bus.LOCKED, bus.SYNC_0, bus.SYNC_1} !== 3'b000) begin
      errors++;
      $display("FAIL after_timeout: got %b required 000", {bus.LOCKED, bus.SYNC_0, bus.SYNC_1});
    end
    checks++;
    if (bus.FRAME_PERIOD !== 24'd1600) begin
      errors++;
      $display("FAIL period_held: got %0d required 1600", bus.FRAME_PERIOD);
    end
    vs_on = 1'b1;
    wait_vsr("relock_edge1");
    skip(1);
    checks++;
    if (bus.LOCKED !== 1'b0) begin
      errors++;
      $display("FAIL relock_one_edge: got %b required 0", bus.LOCKED);
    end
    wait_vsr("relock_edge2");
    skip(1);
    checks++;
    if (bus.LOCKED !== 1'b1) begin
      errors++;
      $display("FAIL relock_two_edges: got %b required 1", bus.LOCKED);
    end
    skip(99);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b00) begin
      errors++;
      $display("FAIL relock_arm_off: got %b required 00", {bus.SYNC_0, bus.SYNC_1});
    end
    skip(405);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b10) begin
      errors++;
      $display("FAIL relock_first_a: got %b required 10", {bus.SYNC_0, bus.SYNC_1});
    end
  endtask

  task automatic test_mode;
    int c0, c1, on, ticks;
    c0 = 0; c1 = 0; on = 0; ticks = 0;
    wait_vsr("mode_edge");
    bus.MODE = 2'b01;
    repeat (3200) begin
      @(negedge clk);
      if (bus.SYNC_0) c0++;
      if (bus.SYNC_1) c1++;
    end
    checks++;
    if (c0 !== 3192 || c1 !== 0) begin
      errors++;
      $display("FAIL mode01_counts: got a=%0d b=%0d required a=3192 b=0", c0, c1);
    end
    bus.MODE = 2'b11;
    repeat (3200) begin
      @(negedge clk);
      if (bus.SYNC_0 || bus.SYNC_1) on++;
      if (bus.FRAME_TICK) ticks++;
    end
    checks++;
    if (on !== 0 || ticks !== 2) begin
      errors++;
      $display("FAIL mode11_counts: got on=%0d ticks=%0d required on=0 ticks=2", on, ticks);
    end
    bus.MODE = 2'b00;
    skip(600);
    checks++;
    if ((bus.SYNC_0 ^ bus.SYNC_1) !== 1'b1) begin
      errors++;
      $display("FAIL mode00_on: got %b required one channel", {bus.SYNC_0, bus.SYNC_1});
    end
    bus.ENABLE = 1'b0;
    skip(1);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1} !== 2'b00) begin
      errors++;
      $display("FAIL disable_off: got %b required 00", {bus.SYNC_0, bus.SYNC_1});
    end
    bus.ENABLE = 1'b1;
  endtask

  task automatic test_reset_mid;
    wait_vsr("reenable_edge");
    skip(50);
    pulse_step(2);
    wait_vsr("idx7_edge");
    skip(1);
    checks++;
    if (bus.OFFSET_IDX !== 4'd7) begin
      errors++;
      $display("FAIL idx_7: got %0d required 7", bus.OFFSET_IDX);
    end
    skip(799);
    checks++;
    if ((bus.SYNC_0 ^ bus.SYNC_1) !== 1'b1) begin
      errors++;
      $display("FAIL on_before_rst: got %b required one channel", {bus.SYNC_0, bus.SYNC_1});
    end
    rst = 1'b1;
    skip(1);
    checks++;
    if ({bus.SYNC_0, bus.SYNC_1, bus.LOCKED, bus.FRAME_TICK} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_flags: got %b required 0000", {bus.SYNC_0, bus.SYNC_1, bus.LOCKED, bus.FRAME_TICK});
    end
    checks++;
    if (bus.OFFSET_IDX !== 4'd0 || bus.FRAME_PERIOD !== 24'd0) begin
      errors++;
      $display("FAIL rst_mid_regs: got idx=%0d period=%0d required 0 0", bus.OFFSET_IDX, bus.FRAME_PERIOD);
    end
    rst = 1'b0;
  endtask

  task automatic test_invariant;
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL both_on: got %0d overlapping cycles required 0", overlap);
    end
  endtask

  initial begin
    bus.ENABLE = 1'b0;
    bus.STEP = 1'b0;
    bus.MODE = 2'b00;
    test_reset;
    test_alternate;
    test_step_offset;
    test_wrap;
    test_timeout;
    test_mode;
    test_reset_mid;
    test_invariant;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
